// File: rtl/sincos_angle_cordic.sv
// Iterative CORDIC vectoring: recovers the angle (1024 units per turn) of a signed 5-bit sine/cosine pair.
// Optional feature: define SINCOS_MAG_OUT_EN to add the unscaled magnitude output port mag.
module sincos_angle_cordic #(
    parameter int unsigned ITERS = 10,
    parameter int unsigned FRAC  = 3
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [4:0] s,
    input  logic [4:0] c,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] a,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SINCOS_MAG_OUT_EN
    ,
    output logic [6:0] mag
`endif
);

    localparam int unsigned IW = 5;
    localparam int unsigned DW = IW + FRAC + 2;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
`ifdef SINCOS_MAG_OUT_EN
    localparam int unsigned MW = 7;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FOLD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic signed [DW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [DW-1:0]  x_sh, y_sh, x_in, y_in;
    logic        [AW-1:0]  z_q, z_d, a_q, a_d, step;
    logic        [CW-1:0]  it_q, it_d;
    logic signed [IW-1:0]  s_q, s_d, c_q, c_d;
    logic                  zero_q, zero_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
`ifdef SINCOS_MAG_OUT_EN
    logic        [MW-1:0]  mag_q, mag_d;
`endif

    // atan(2^-i) in angle units, rounded to nearest
    function automatic logic [AW-1:0] atan_lut(input logic [CW-1:0] i);
        case (int'(i))
            0:       return AW'(128);
            1:       return AW'(76);
            2:       return AW'(40);
            3:       return AW'(20);
            4:       return AW'(10);
            5:       return AW'(5);
            6:       return AW'(3);
            7:       return AW'(1);
            8:       return AW'(1);
            default: return AW'(0);
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        a_d      = a_q;
        it_d     = it_q;
        s_d      = s_q;
        c_d      = c_q;
        zero_d   = zero_q;
`ifdef SINCOS_MAG_OUT_EN
        mag_d    = mag_q;
`endif
        x_sh     = x_q >>> it_q;
        y_sh     = y_q >>> it_q;
        x_in     = DW'(c_q) <<< FRAC;
        y_in     = DW'(s_q) <<< FRAC;
        step     = atan_lut(it_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = s;
                    c_d     = c;
                    zero_d  = (s == '0) && (c == '0);
                    state_d = FOLD;
                end
            end
            FOLD: begin
                // Left half-plane vectors are rotated by half a turn first
                if (c_q[IW-1]) begin
                    x_d = -x_in;
                    y_d = -y_in;
                    z_d = AW'(512);
                end else begin
                    x_d = x_in;
                    y_d = y_in;
                    z_d = '0;
                end
                it_d    = '0;
                state_d = ROTATE;
            end
            ROTATE: begin
                if (!y_q[DW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + step;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - step;
                end
                if (it_q == CW'(ITERS - 1)) begin
                    state_d = DONE;
                    // A zero vector has no angle; report 0 instead of the accumulated LUT sum
                    a_d     = zero_q ? '0 : z_d;
`ifdef SINCOS_MAG_OUT_EN
                    mag_d   = MW'(x_d >>> FRAC);
`endif
                end else begin
                    it_d = it_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            a_q         <= '0;
            it_q        <= '0;
            s_q         <= '0;
            c_q         <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SINCOS_MAG_OUT_EN
            mag_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            a_q         <= a_d;
            it_q        <= it_d;
            s_q         <= s_d;
            c_q         <= c_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SINCOS_MAG_OUT_EN
            mag_q       <= mag_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign a         = a_q;
`ifdef SINCOS_MAG_OUT_EN
    assign mag       = mag_q;
`endif

endmodule
